inst_queue: RTL
===============

// Module: inst_queue
// PURPOSE
//  Parametrised instruction register/queue between fetch and decode. Buffers up to DEPTH
//  fetched instruction words, each with its PC, under valid/ready handshakes on both sides.
//  Presents the head entry with fixed MIPS32 field slicing (opcode/funct/rs/rt/rd/imm16/index26).
//  Flush discards all entries on branch/jump redirect.
// PARAMETERS
//  DEPTH  4   entries; power of two, >= 2
//  PC_W   32  PC width stored alongside each instruction
// PORTS
//  clk           in   1             rising-edge clock
//  rst_n         in   1             asynchronous reset, active-low
//  flush         in   1             drop all entries (synchronous)
//  in_valid      in   1             fetch offers in_inst/in_pc
//  in_ready      out  1             queue accepts this cycle
//  in_inst       in   32            instruction word
//  in_pc         in   PC_W          PC of in_inst
//  out_valid     out  1             head entry valid
//  out_ready     in   1             decode consumes head this cycle
//  out_inst      out  32            head instruction word
//  out_pc        out  PC_W          head PC
//  opcode        out  6             out_inst[31:26]
//  funct         out  6             out_inst[5:0]
//  rs/rt/rd      out  5 each        out_inst[25:21]/[20:16]/[15:11]
//  imm16         out  16            out_inst[15:0]
//  inst_index26  out  26            out_inst[25:0]
//  count         out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Circular buffer: wr_ptr, rd_ptr each $clog2(DEPTH) bits, wrap DEPTH-1 -> 0; count separate.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both may occur in one cycle.
//  - in_ready = (count != DEPTH) & ~flush; registered-state only, no comb path from out_ready.
//    Full queue with pop in same cycle: in_ready stays 0 (no pass-through when full).
//  - out_valid = (count != 0); out_* and field outputs slice the entry at rd_ptr, combinational.
//  - Latency: a pushed word appears at out_* the cycle after acceptance (macro off).
//  - push&pop same cycle: count unchanged, both pointers advance.
//  - flush: next edge count=0, wr_ptr=rd_ptr=0; concurrent push/pop ignored; storage untouched.
//  - Reset (async, rst_n=0): pointers 0, count 0, all storage 0 => out_valid=0, in_ready=1
//    after release, out_inst/out_pc/fields all 0. Reset mid-stream drops everything in flight.
//  - Entries never overwritten while occupied; pop with count=0 impossible (out_valid=0).
//  - Field slicing is pure wiring of out_inst; no sign extension here.
// CONFIGURATION
//  IQ_BYPASS_EN defined: when count==0 and in_valid, out_valid=1 and out_* = in_inst/in_pc
//    combinationally; if out_ready also 1 the word is consumed and not written (count stays 0).
//    in_ready unchanged in definition. Adds in->out comb path.
//  IQ_BYPASS_EN undefined: no bypass; minimum 1-cycle latency as above.
// TESTING
//  1 Reset: rst_n=0 mid-burst -> out_valid=0, count=0, opcode=0, in_ready=1 after release.
//  2 Push 0x8C220004 @pc 0x100, out_ready=0 -> next cycle out_valid=1, opcode=0x23, rs=1,
//    rt=2, imm16=0x0004, out_pc=0x100, count=1.
//  3 DEPTH=4: push 5 words, out_ready=0 -> 4 accepted, in_ready=0, count=4; then pop all ->
//    order preserved across pointer wrap, count returns 0.
//  4 count=2, push&pop same cycle -> count stays 2, head advances to next word.
//  5 count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, new word not stored.
//  6 IQ_BYPASS_EN, empty, in_valid=out_ready=1, 0x00851020 -> same cycle out_valid=1,
//    funct=0x20, rd=2, count stays 0; macro off -> out_valid=0 that cycle, count=1 after.

Source files
------------

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//   Instruction queue between fetch and decode. It holds up to DEPTH fetched
//   instruction words, each stored with its PC, and uses valid/ready handshakes
//   on both sides. The head entry is presented with fixed MIPS32 field slicing.
//   A flush empties the queue on a branch or jump redirect.
//
//   Optional feature: define IQ_BYPASS_EN to send a word straight from the
//   input to the output when the queue is empty. This adds a combinational
//   path from in_* to out_*. By default the macro is undefined and a word
//   becomes visible one cycle after it is accepted.
//
// Ports
//   clk, rst_n          clock (rising edge) and async active-low reset
//   flush               drop every entry on the next edge (synchronous)
//   in_valid/in_ready   fetch-side handshake; in_inst, in_pc are the payload
//   out_valid/out_ready decode-side handshake; out_inst, out_pc are the head
//   opcode..index26     MIPS32 fields sliced directly from out_inst
//   count               number of occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [PC_W-1:0]          out_pc,
  output logic [5:0]               opcode,
  output logic [5:0]               funct,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [15:0]              imm16,
  output logic [25:0]              inst_index26,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned INST_W = 32;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic [PC_W-1:0]   pc_mem_q   [DEPTH];
  logic [PC_W-1:0]   pc_mem_d   [DEPTH];

  logic empty_c;
  logic full_c;
  logic bypass_c;
  logic push_c;
  logic pop_c;
  logic wr_en_c;
  logic rd_en_c;

  // Occupancy flags come from registered state only.
  assign empty_c  = (count_q == '0);
  assign full_c   = (count_q == CNT_W'(DEPTH));

  // A full queue refuses new words even if decode pops in the same cycle.
  assign in_ready = ~full_c & ~flush;

`ifdef IQ_BYPASS_EN
  // A word arriving at an empty queue is shown to decode immediately. A word
  // that arrives during a redirect is stale, so it is never bypassed.
  assign bypass_c = empty_c & in_valid & ~flush;
`else
  assign bypass_c = 1'b0;
`endif

  assign out_valid = ~empty_c | bypass_c;
  assign out_inst  = bypass_c ? in_inst : inst_mem_q[rd_ptr_q];
  assign out_pc    = bypass_c ? in_pc   : pc_mem_q[rd_ptr_q];

  // MIPS32 field views of the head word. These are plain wires with no sign extension.
  assign opcode       = out_inst[31:26];
  assign rs           = out_inst[25:21];
  assign rt           = out_inst[20:16];
  assign rd           = out_inst[15:11];
  assign funct        = out_inst[5:0];
  assign imm16        = out_inst[15:0];
  assign inst_index26 = out_inst[25:0];

  assign count = count_q;

  assign push_c  = in_valid & in_ready;
  assign pop_c   = out_valid & out_ready;
  // A bypassed word that decode consumes in the same cycle is never stored.
  assign wr_en_c = push_c & ~(bypass_c & out_ready);
  assign rd_en_c = pop_c & ~empty_c;

  // Next-state logic for pointers, occupancy and storage.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;

    if (flush) begin
      // Storage is left as it is; only the bookkeeping is reset.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_c) begin
        inst_mem_d[wr_ptr_q] = in_inst;
        pc_mem_d[wr_ptr_q]   = in_pc;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_en_c, rd_en_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers. Reset also clears storage so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

endmodule
